// File: rtl/poly_div.sv
// poly_div: sequential synthetic division of a K-coefficient polynomial by the
// monic linear divisor (x + d), all coefficient arithmetic modulo 2^N.
module poly_div #(
  parameter int N = 2,
  parameter int K = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [K*N-1:0]     p,
  input  logic [N-1:0]       d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [(K-1)*N-1:0] q,
  output logic [N-1:0]       r
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // idx walks K-2 down to 0; keep it at least one bit wide for K=2
  localparam int IW = (K > 2) ? $clog2(K-1) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(K-2);

  logic [1:0]     state;
  logic [K*N-1:0] p_reg;
  logic [N-1:0]   d_reg;
  logic [N-1:0]   t;
  logic [N-1:0]   t_next;
  logic [N-1:0]   p_coef;
  logic [N-1:0]   dt;
  logic [IW-1:0]  idx;

  // d*t keeps only its low N bits, and the subtraction wraps mod 2^N
  always_comb begin
    p_coef = p_reg[int'(idx)*N +: N];
    dt     = d_reg * t;
    t_next = p_coef - dt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      p_reg <= '0;
      d_reg <= '0;
      t     <= '0;
      idx   <= '0;
      q     <= '0;
      r     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            p_reg <= p;
            d_reg <= d;
            t     <= p[K*N-1 -: N];
            idx   <= IDX_TOP;
            state <= RUN;
          end
        end
        RUN: begin
          q[int'(idx)*N +: N] <= t;
          t <= t_next;
          if (idx == '0) begin
            r     <= t_next;
            state <= DONE;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_poly_div.sv
// Bench for poly_div: directed cases at N=2,K=3 plus random regression at N=2,K=3 and N=8,K=5.
module tb_poly_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv_s, ir_s, ov_s, or_s;
  logic [5:0] p_s;
  logic [1:0] d_s, r_s;
  logic [3:0] q_s;

  logic        iv_l, ir_l, ov_l, or_l;
  logic [39:0] p_l;
  logic [7:0]  d_l, r_l;
  logic [31:0] q_l;

  int n_cmp = 0;
  int n_err = 0;

  poly_div #(.N(2), .K(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s), .p(p_s), .d(d_s),
    .out_valid(ov_s), .out_ready(or_s), .q(q_s), .r(r_s)
  );

  poly_div #(.N(8), .K(5)) dut_l (
    .clk(clk), .rst(rst), .in_valid(iv_l), .in_ready(ir_l), .p(p_l), .d(d_l),
    .out_valid(ov_l), .out_ready(or_l), .q(q_l), .r(r_l)
  );

  // Reference: p = a*(x+d) + rm, built by polynomial multiplication mod 2^n.
  // Division by a monic divisor is unique, so the expected quotient is a and the remainder rm.
  function automatic logic [63:0] build_p(input logic [63:0] a, input int dv, input int rm,
                                          input int n, input int k);
    logic [63:0] res;
    int mask, lo, hi, c;
    res  = '0;
    mask = (1 << n) - 1;
    for (int i = 0; i < k; i++) begin
      lo = (i > 0)     ? int'((a >> ((i-1)*n)) & 64'(mask)) : 0;
      hi = (i < k - 1) ? int'((a >> (i*n)) & 64'(mask))     : 0;
      c  = (lo + dv*hi + ((i == 0) ? rm : 0)) & mask;
      res = res | (64'(c) << (i*n));
    end
    return res;
  endfunction

  task automatic start_s(input logic [5:0] pv, input logic [1:0] dv);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_s) break;
    end
    n_cmp++;
    if (ir_s !== 1'b1) begin
      n_err++;
      $display("FAIL start_s_ready: in_ready=%b want 1", ir_s);
    end
    p_s = pv; d_s = dv; iv_s = 1'b1;
    @(posedge clk); #1;
    iv_s = 1'b0; p_s = 6'($urandom); d_s = 2'($urandom);
  endtask

  task automatic wait_valid_s(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ov_s) begin lat = i; break; end
    end
    if (lat == 0) begin
      n_cmp++; n_err++;
      $display("FAIL wait_valid_s: out_valid never rose within 20 cycles");
    end
  endtask

  task automatic consume_s();
    or_s = 1'b1;
    @(posedge clk); #1;
    or_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv_s = 1'b0; or_s = 1'b0; p_s = '0; d_s = '0;
    iv_l = 1'b0; or_l = 1'b0; p_l = '0; d_l = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp += 8;
    if (ir_s !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_s: got %b want 1", ir_s); end
    if (ov_s !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_s: got %b want 0", ov_s); end
    if (q_s !== 4'd0)  begin n_err++; $display("FAIL reset_q_s: got %h want 0", q_s); end
    if (r_s !== 2'd0)  begin n_err++; $display("FAIL reset_r_s: got %h want 0", r_s); end
    if (ir_l !== 1'b1) begin n_err++; $display("FAIL reset_in_ready_l: got %b want 1", ir_l); end
    if (ov_l !== 1'b0) begin n_err++; $display("FAIL reset_out_valid_l: got %b want 0", ov_l); end
    if (q_l !== 32'd0) begin n_err++; $display("FAIL reset_q_l: got %h want 0", q_l); end
    if (r_l !== 8'd0)  begin n_err++; $display("FAIL reset_r_l: got %h want 0", r_l); end
  endtask

  task automatic test_directed(input string name, input logic [5:0] pv, input logic [1:0] dv,
                               input logic [3:0] eq, input logic [1:0] er);
    int lat;
    start_s(pv, dv);
    wait_valid_s(lat);
    n_cmp += 3;
    if (q_s !== eq) begin n_err++; $display("FAIL %s_q: got %b want %b", name, q_s, eq); end
    if (r_s !== er) begin n_err++; $display("FAIL %s_r: got %b want %b", name, r_s, er); end
    if (lat != 3)   begin n_err++; $display("FAIL %s_latency: got %0d want 3", name, lat); end
    consume_s();
  endtask

  task automatic test_backpressure();
    int  lat;
    bit  got_a, accepted;
    start_s(6'b11_11_11, 2'd3);
    @(negedge clk);
    n_cmp++;
    if (ir_s !== 1'b0) begin n_err++; $display("FAIL run_in_ready: got %b want 0", ir_s); end
    wait_valid_s(lat);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      iv_s = 1'b1; p_s = 6'b000001; d_s = 2'd1;
      @(negedge clk);
      n_cmp += 4;
      if (ov_s !== 1'b1)    begin n_err++; $display("FAIL bp_out_valid[%0d]: got %b want 1", c, ov_s); end
      if (q_s !== 4'b1110)  begin n_err++; $display("FAIL bp_q[%0d]: got %b want 1110", c, q_s); end
      if (r_s !== 2'd1)     begin n_err++; $display("FAIL bp_r[%0d]: got %b want 01", c, r_s); end
      if (ir_s !== 1'b0)    begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want 0", c, ir_s); end
    end
    iv_s = 1'b0;
    or_s = 1'b1;
    @(posedge clk); #1;
    or_s = 1'b0;
    @(negedge clk);
    n_cmp += 3;
    if (ir_s !== 1'b1)   begin n_err++; $display("FAIL release_in_ready: got %b want 1", ir_s); end
    if (ov_s !== 1'b0)   begin n_err++; $display("FAIL release_out_valid: got %b want 0", ov_s); end
    if (q_s !== 4'b1110) begin n_err++; $display("FAIL release_q_hold: got %b want 1110", q_s); end

    // back-to-back with out_ready held high and the next job already waiting
    or_s = 1'b1;
    start_s(6'b01_01_10, 2'd3);
    iv_s = 1'b1; p_s = 6'b10_01_11; d_s = 2'd0;
    got_a = 1'b0; accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ov_s && !got_a) begin
        got_a = 1'b1;
        n_cmp += 2;
        if (q_s !== 4'b0110) begin n_err++; $display("FAIL b2b_a_q: got %b want 0110", q_s); end
        if (r_s !== 2'd0)    begin n_err++; $display("FAIL b2b_a_r: got %b want 00", r_s); end
      end else if (ir_s) begin
        @(posedge clk); #1;
        iv_s = 1'b0;
        accepted = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!(got_a && accepted)) begin
      n_err++;
      $display("FAIL b2b_handshake: got_a=%b accepted=%b want 1 1", got_a, accepted);
    end
    iv_s = 1'b0;
    or_s = 1'b0;
    wait_valid_s(lat);
    n_cmp += 2;
    if (q_s !== 4'b1001) begin n_err++; $display("FAIL b2b_b_q: got %b want 1001", q_s); end
    if (r_s !== 2'd3)    begin n_err++; $display("FAIL b2b_b_r: got %b want 11", r_s); end
    consume_s();
  endtask

  task automatic test_reset_mid_run();
    start_s(6'b11_11_11, 2'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (ov_s !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b want 0", ov_s); end
    if (q_s !== 4'd0)  begin n_err++; $display("FAIL midrst_q: got %b want 0000", q_s); end
    if (r_s !== 2'd0)  begin n_err++; $display("FAIL midrst_r: got %b want 00", r_s); end
    if (ir_s !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b want 1", ir_s); end
    test_directed("after_reset", 6'b01_01_10, 2'd3, 4'b0110, 2'd0);
  endtask

  task automatic test_random_small();
    logic [63:0] pp;
    logic [3:0]  a;
    logic [1:0]  dv, rm;
    int lat;
    for (int j = 0; j < 12; j++) begin
      a  = 4'($urandom);
      dv = 2'($urandom);
      rm = 2'($urandom);
      pp = build_p(64'(a), int'(dv), int'(rm), 2, 3);
      start_s(pp[5:0], dv);
      wait_valid_s(lat);
      n_cmp += 2;
      if (q_s !== a)  begin n_err++; $display("FAIL rand_s_q[%0d]: got %h want %h", j, q_s, a); end
      if (r_s !== rm) begin n_err++; $display("FAIL rand_s_r[%0d]: got %h want %h", j, r_s, rm); end
      consume_s();
    end
  endtask

  task automatic test_random_large();
    logic [63:0] pp;
    logic [31:0] a;
    logic [7:0]  dv, rm;
    int lat;
    for (int j = 0; j < 25; j++) begin
      a  = $urandom;
      dv = 8'($urandom);
      rm = 8'($urandom);
      if (j == 0) dv = 8'd0;
      pp = build_p(64'(a), int'(dv), int'(rm), 8, 5);
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ir_l) break;
      end
      n_cmp++;
      if (ir_l !== 1'b1) begin n_err++; $display("FAIL rand_l_ready[%0d]: got %b want 1", j, ir_l); end
      p_l = pp[39:0]; d_l = dv; iv_l = 1'b1;
      @(posedge clk); #1;
      iv_l = 1'b0; p_l = {$urandom, 8'($urandom)}; d_l = 8'($urandom);
      lat = 0;
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        if (ov_l) begin lat = i; break; end
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      n_cmp += 3;
      if (lat != 5)   begin n_err++; $display("FAIL rand_l_latency[%0d]: got %0d want 5", j, lat); end
      if (q_l !== a)  begin n_err++; $display("FAIL rand_l_q[%0d]: got %h want %h", j, q_l, a); end
      if (r_l !== rm) begin n_err++; $display("FAIL rand_l_r[%0d]: got %h want %h", j, r_l, rm); end
      or_l = 1'b1;
      @(posedge clk); #1;
      or_l = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_directed("inverse", 6'b01_01_10, 2'd3, 4'b0110, 2'd0);
    test_directed("wrap",    6'b11_11_11, 2'd3, 4'b1110, 2'd1);
    test_directed("rem",     6'b00_00_01, 2'd1, 4'b0000, 2'd1);
    test_directed("d_zero",  6'b10_01_11, 2'd0, 4'b1001, 2'd3);
    test_backpressure();
    test_reset_mid_run();
    test_random_small();
    test_random_large();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
